// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front end for the board's slide switches and push button.
// Each raw input is synchronised into CLOCK and then debounced.
// The block derives clean change, press and release pulses.
// It also produces a single-cycle TICK enable, which downstream logic uses
// instead of a derived clock.
// All outputs come straight from flops.
//
// Ports
//   CLOCK          in   system clock
//   RESET_N        in   asynchronous active-low reset
//   SWITCHES_RAW   in   [3:0] raw slide switches (asynchronous)
//   BTN0_RAW       in   raw push button, active-high (asynchronous)
//   SWITCHES_DB    out  [3:0] debounced switch levels
//   SWITCH_CHANGE  out  one-cycle pulse when any debounced switch bit changes
//   BTN0_LEVEL     out  debounced button level
//   BTN0_PRESS     out  one-cycle pulse on debounced 0->1
//   BTN0_RELEASE   out  one-cycle pulse on debounced 1->0
//   TICK           out  one-cycle enable every TICK_DIV cycles
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_DIV        = 33554432
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [3:0] SWITCHES_RAW,
  input  logic       BTN0_RAW,
  output logic [3:0] SWITCHES_DB,
  output logic       SWITCH_CHANGE,
  output logic       BTN0_LEVEL,
  output logic       BTN0_PRESS,
  output logic       BTN0_RELEASE,
  output logic       TICK
);

  localparam int NB   = 5;  // bits [3:0] switches, bit 4 button
  localparam int BTN  = 4;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TK_W = $clog2(TICK_DIV);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [TK_W-1:0] TK_ONE  = TK_W'(1);

  logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
  logic [NB-1:0]                  sync_bits;
  logic [NB-1:0][DB_W-1:0]        cnt_q, cnt_d;
  logic [NB-1:0]                  db_q, db_d;
  logic                           press_d, release_d, change_d;
  logic                           press_q, release_q, change_q;
  logic [TK_W-1:0]                tick_cnt_q, tick_cnt_d;
  logic                           tick_q, tick_d;
  logic                           wrap;

  // Last synchroniser stage is the only view of the raw inputs.
  assign sync_bits = sync_q[SYNC_STAGES-1];

  // Per-bit debounce.
  // The count holds the number of consecutive cycles the synchronised bit
  // has disagreed with the debounced bit.
  // Agreement clears it, so a bounce restarts the count.
  // The DEBOUNCE_CYCLES-th disagreement commits the new value and clears
  // the count, so the count never goes past DEBOUNCE_CYCLES-1.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync_bits[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = sync_bits[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_ONE;
      end
    end
  end

  // Pulses are computed from next-state.
  // They then go high in the same cycle the new level first appears.
  assign press_d   =  db_d[BTN] & ~db_q[BTN];
  assign release_d = ~db_d[BTN] &  db_q[BTN];
  assign change_d  = |(db_d[3:0] ^ db_q[3:0]);

  // Tick divider.
  // A debounced press restarts the period and takes priority over a
  // coincident wrap, so no TICK is issued on that edge.
  assign wrap       = (tick_cnt_q == TK_LAST);
  assign tick_cnt_d = (press_d || wrap) ? '0 : tick_cnt_q + TK_ONE;
  assign tick_d     = wrap & ~press_d;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      db_q       <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      change_q   <= 1'b0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], {BTN0_RAW, SWITCHES_RAW}};
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      press_q    <= press_d;
      release_q  <= release_d;
      change_q   <= change_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign SWITCHES_DB   = db_q[3:0];
  assign BTN0_LEVEL    = db_q[BTN];
  assign SWITCH_CHANGE = change_q;
  assign BTN0_PRESS    = press_q;
  assign BTN0_RELEASE  = release_q;
  assign TICK          = tick_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TICK_DIV=8.
//
// The reference model treats the synchroniser as a pure delay line.
// A debounced bit flips once the last DEBOUNCE_CYCLES delayed samples all
// disagree with it.
// TICK fires when the number of edges since reset (or since the last press)
// is a multiple of TICK_DIV.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int SYNC = 2;
  localparam int DBC  = 4;
  localparam int TD   = 8;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic [3:0] SWITCHES_RAW;
  logic       BTN0_RAW;
  logic [3:0] SWITCHES_DB;
  logic       SWITCH_CHANGE;
  logic       BTN0_LEVEL;
  logic       BTN0_PRESS;
  logic       BTN0_RELEASE;
  logic       TICK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DBC),
    .TICK_DIV       (TD)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .SWITCHES_RAW (SWITCHES_RAW),
    .BTN0_RAW     (BTN0_RAW),
    .SWITCHES_DB  (SWITCHES_DB),
    .SWITCH_CHANGE(SWITCH_CHANGE),
    .BTN0_LEVEL   (BTN0_LEVEL),
    .BTN0_PRESS   (BTN0_PRESS),
    .BTN0_RELEASE (BTN0_RELEASE),
    .TICK         (TICK)
  );

  always #5 CLOCK = ~CLOCK;

  // ---------------- reference model ----------------
  logic [4:0] dly_q[$];
  logic [4:0] win_q[$];
  logic [4:0] m_db, nd, seen;
  logic       m_press, m_rel, m_chg, m_tick, all_diff;
  int         m_since;

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      dly_q.delete();
      for (int i = 0; i < SYNC; i++) dly_q.push_back(5'b0);
      win_q.delete();
      m_db = '0; m_since = 0;
      m_press = 0; m_rel = 0; m_chg = 0; m_tick = 0;
    end else begin
      seen = dly_q.pop_front();
      dly_q.push_back({BTN0_RAW, SWITCHES_RAW});
      win_q.push_back(seen);
      if (win_q.size() > DBC) void'(win_q.pop_front());
      nd = m_db;
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        foreach (win_q[j]) if (win_q[j][b] == m_db[b]) all_diff = 1'b0;
        if (win_q.size() == DBC && all_diff) nd[b] = ~m_db[b];
      end
      m_press = nd[4] & ~m_db[4];
      m_rel   = ~nd[4] & m_db[4];
      m_chg   = |(nd[3:0] ^ m_db[3:0]);
      if (m_press) begin
        m_since = 0;
        m_tick  = 1'b0;
      end else begin
        m_since = m_since + 1;
        m_tick  = (m_since % TD) == 0;
      end
      m_db = nd;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge CLOCK);
      if (chk_en)
        check("cycle",
              {22'd0, SWITCHES_DB, SWITCH_CHANGE, BTN0_LEVEL, BTN0_PRESS, BTN0_RELEASE, TICK},
              {22'd0, m_db[3:0], m_chg, m_db[4], m_press, m_rel, m_tick});
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {SWITCHES_DB, SWITCH_CHANGE, BTN0_LEVEL, BTN0_PRESS, BTN0_RELEASE, TICK};
  endfunction

  logic [24:0] pat;
  logic [4:0]  rnd;

  initial begin
    RESET_N = 1'b0;
    SWITCHES_RAW = 4'b1111;
    BTN0_RAW = 1'b0;
    fork compare_loop(); join_none
    step();
    chk_en = 1'b1;
    repeat (2) step();

    // Reset held with switches high: everything low.
    check("rst_outs", {22'd0, outs()}, 32'd0);
    RESET_N = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t1_db", {28'd0, SWITCHES_DB}, (k >= 6) ? 32'hF : 32'h0);
      check("t1_chg", {31'd0, SWITCH_CHANGE}, {31'd0, (k == 6)});
    end
    repeat (4) step();

    // Short pulse and bounce: no debounced change.
    pat = 25'b1110000000111011100000000;
    for (int k = 0; k < 25; k++) begin
      BTN0_RAW = pat[24-k];
      step();
      check("t2_btn", {30'd0, BTN0_LEVEL, BTN0_PRESS}, 32'd0);
    end

    // Clean press then release.
    BTN0_RAW = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t3_lvl", {31'd0, BTN0_LEVEL}, {31'd0, (k >= 6)});
      check("t3_press", {31'd0, BTN0_PRESS}, {31'd0, (k == 6)});
    end
    BTN0_RAW = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t3_lvl_f", {31'd0, BTN0_LEVEL}, {31'd0, (k < 6)});
      check("t3_rel", {31'd0, BTN0_RELEASE}, {31'd0, (k == 6)});
    end

    // Free-running tick.
    SWITCHES_RAW = 4'b0000;
    RESET_N = 1'b0;
    repeat (2) step();
    RESET_N = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("t4_tick", {31'd0, TICK}, {31'd0, (k % 8 == 0)});
    end

    // Press landing on a wrap edge (edge 16) suppresses TICK and restarts.
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 11) BTN0_RAW = 1'b1;
      step();
      check("t5_tick", {31'd0, TICK}, {31'd0, (k == 8 || k == 24)});
      check("t5_press", {31'd0, BTN0_PRESS}, {31'd0, (k == 16)});
    end
    BTN0_RAW = 1'b0;
    repeat (12) step();

    // Reset mid-debounce and mid-count.
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    SWITCHES_RAW = 4'b0100;
    repeat (4) step();
    check("t6_pre", {28'd0, SWITCHES_DB}, 32'd0);
    RESET_N = 1'b0;
    #1;
    check("t6_rst", {22'd0, outs()}, 32'd0);
    step();
    RESET_N = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t6_db2", {31'd0, SWITCHES_DB[2]}, {31'd0, (k >= 6)});
      check("t6_chg", {31'd0, SWITCH_CHANGE}, {31'd0, (k == 6)});
      check("t6_tick", {31'd0, TICK}, {31'd0, (k == 8)});
    end

    // Randomised traffic with occasional resets, checked by the model.
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        RESET_N = 1'b0;
        repeat ($urandom_range(1, 2)) step();
        RESET_N = 1'b1;
      end
      rnd = 5'($urandom);
      SWITCHES_RAW = rnd[3:0];
      BTN0_RAW = rnd[4];
      repeat ($urandom_range(1, 9)) step();
    end
    repeat (12) step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end stage for the board's switch and button inputs. It synchronises and debounces SWITCHES[3:0] and BTN0, produces clean press/release/change pulses, and generates a single-cycle TICK enable. The downstream one-hot LED game logic runs in the CLOCK domain, gated by TICK, instead of using a derived clock. All outputs are registered.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per raw input (legal: >=2)
DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must differ from its debounced value before the debounced value updates (legal: >=1; 10 ms at 100 MHz)
TICK_DIV, 33554432, TICK period in CLOCK cycles (legal: >=2; 2^25)

Ports:
CLOCK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
SWITCHES_RAW  in  4  raw slide switches, asynchronous
BTN0_RAW  in  1  raw push button, asynchronous, active-high
SWITCHES_DB  out  4  debounced switch levels
SWITCH_CHANGE  out  1  one-cycle pulse when any SWITCHES_DB bit changes
BTN0_LEVEL  out  1  debounced button level
BTN0_PRESS  out  1  one-cycle pulse on debounced 0->1
BTN0_RELEASE  out  1  one-cycle pulse on debounced 1->0
TICK  out  1  one-cycle enable every TICK_DIV cycles

Behaviour:
- Reset, asynchronous, RESET_N=0:
  - All synchroniser flops, debounce counters, debounced levels and the tick counter clear to 0.
  - All outputs are 0 while reset is held.
  - After release, operation resumes at the next CLOCK rising edge.
- Synchroniser: each of the 5 raw bits passes through SYNC_STAGES flops. Nothing downstream reads a raw bit.
- Debounce: one independent counter per bit, width $clog2(DEBOUNCE_CYCLES+1).
  - If sync bit == debounced bit, the counter clears to 0.
  - If they differ, the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, the debounced bit takes the sync value and the counter clears.
- Debounce latency: a raw change held stable appears on the debounced output exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw value.
- Glitch rejection:
  - Any excursion shorter than DEBOUNCE_CYCLES, measured after synchronisation, causes no output change.
  - A bounce back to the debounced value restarts the count from 0.
- Pulse outputs:
  - BTN0_PRESS, BTN0_RELEASE and SWITCH_CHANGE are registered.
  - Each is high for exactly the first cycle in which the new debounced value is visible.
  - Simultaneous changes on several switch bits give one SWITCH_CHANGE pulse.
  - Press and release never coincide.
- Tick counter: width $clog2(TICK_DIV), counts 0..TICK_DIV-1, then wraps to 0.
  - TICK is registered. It is high for one cycle after each wrap.
  - The first TICK follows the TICK_DIV-th rising edge after reset release.
  - Pulse spacing is exactly TICK_DIV cycles.
- Tick restart:
  - The edge that raises BTN0_PRESS also forces the tick counter to 0.
  - If that edge coincides with a wrap, TICK is suppressed for that cycle; the press wins.
  - The next TICK follows TICK_DIV edges later.
- Reset mid-debounce or mid-count: pending changes are discarded. After release, raw inputs already at 1 are debounced from scratch, with the full latency and the corresponding change/press pulses.
- Counter widths never overflow. Counters saturate only by their compare-and-clear logic, and no wrap beyond a terminal value is permitted.

Test Plan:
Use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TICK_DIV=8 for all cases.
1. Hold RESET_N=0 with SWITCHES_RAW=4'b1111, BTN0_RAW=0 -> all outputs 0. Release -> SWITCHES_DB=4'b1111 and a single SWITCH_CHANGE pulse 6 edges after the first post-release edge.
2. BTN0_RAW high for 3 cycles, then low -> BTN0_LEVEL stays 0 and no BTN0_PRESS. A 3-high/1-low/3-high bounce also gives no change.
3. BTN0_RAW high for 12 cycles, then low -> BTN0_LEVEL rises 6 edges after the rise with BTN0_PRESS high for exactly that first cycle. BTN0_LEVEL falls 6 edges after the fall with a one-cycle BTN0_RELEASE.
4. Free-run 24 cycles after reset with no input activity -> TICK pulses after edges 8, 16 and 24, each exactly 1 cycle wide.
5. Time a clean press so BTN0_PRESS lands on a wrap edge -> TICK is absent that cycle. The next TICK comes 8 edges after the BTN0_PRESS edge.
6. Assert RESET_N=0 for 1 cycle while a SWITCHES_RAW[2] change is 2 cycles into debounce, with TICK at count 5 -> outputs 0 immediately. After release, SWITCHES_DB[2] updates 6 edges later and the first TICK comes 8 edges later.
